vid_timing_gen: RTL and testbench

Parametrised video timing generator that replaces the hard-coded combinational sync/blank/request decode in the camera-to-VGA top level. It owns free-running pixel and line counters and emits registered sync, blank, data-request, row/col and frame/line strobes. A programmable delay line keeps sync and blank aligned with downstream processing latency (for example, the convolution kernel). It adds counter enable, external resync to the camera frame, and configurable sync polarity.

---
 rtl/vid_timing_gen.sv | 135 +++++++++++++
 tb/tb_vid_timing_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vid_timing_gen.sv
// Video timing generator: free-running x/y counters with registered sync/blank/request decode.
// Stage-0 outputs lag the counter by one enabled cycle; hs/vs/blank lag by a further PIPE_DELAY.
module vid_timing_gen #(
  parameter int COORD_W      = 13,
  parameter int H_TOTAL      = 800,
  parameter int H_ACT_START  = 160,
  parameter int H_SYNC_START = 2,
  parameter int H_SYNC_END   = 97,
  parameter int V_TOTAL      = 525,
  parameter int V_ACT_START  = 45,
  parameter int V_SYNC_START = 13,
  parameter int V_SYNC_END   = 14,
  parameter int COL_OFS      = 4,
  parameter int ROW_OFS      = 2,
  parameter int PIPE_DELAY   = 0,
  parameter int HS_POL       = 0,
  parameter int VS_POL       = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               resync_i,
  output logic [COORD_W-1:0] x_count,
  output logic [COORD_W-1:0] y_count,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               req_o,
  output logic               line_start_o,
  output logic               frame_start_o,
  output logic               hs_o,
  output logic               vs_o,
  output logic               blank_no
);

  localparam logic [COORD_W-1:0] LP_H_LAST  = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] LP_V_LAST  = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] LP_H_ACT   = COORD_W'(H_ACT_START);
  localparam logic [COORD_W-1:0] LP_V_ACT   = COORD_W'(V_ACT_START);
  localparam logic [COORD_W-1:0] LP_HS_BEG  = COORD_W'(H_SYNC_START);
  localparam logic [COORD_W-1:0] LP_HS_END  = COORD_W'(H_SYNC_END);
  localparam logic [COORD_W-1:0] LP_VS_BEG  = COORD_W'(V_SYNC_START);
  localparam logic [COORD_W-1:0] LP_VS_END  = COORD_W'(V_SYNC_END);
  localparam logic [COORD_W-1:0] LP_COL_SUB = COORD_W'(H_ACT_START + COL_OFS);
  localparam logic [COORD_W-1:0] LP_ROW_SUB = COORD_W'(V_ACT_START + ROW_OFS);
  localparam logic               LP_HS_INV  = (HS_POL == 0);
  localparam logic               LP_VS_INV  = (VS_POL == 0);

  generate
    if (H_SYNC_END >= H_ACT_START || V_SYNC_END >= V_ACT_START || PIPE_DELAY > 15 || PIPE_DELAY < 0) begin : g_param_err
      $error("vid_timing_gen: illegal timing parameters");
    end
  endgenerate

  logic [COORD_W-1:0] r_x, r_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (resync_i) begin
      r_x <= '0;
      r_y <= '0;
    end else if (en_i) begin
      if (r_x == LP_H_LAST) begin
        r_x <= '0;
        r_y <= (r_y == LP_V_LAST) ? '0 : r_y + COORD_W'(1);
      end else begin
        r_x <= r_x + COORD_W'(1);
      end
    end
  end

  logic w_hs_act, w_vs_act, w_blank_act, w_req;
  assign w_hs_act    = (r_x >= LP_HS_BEG) && (r_x <= LP_HS_END);
  assign w_vs_act    = (r_y >= LP_VS_BEG) && (r_y <= LP_VS_END);
  assign w_blank_act = (r_x < LP_H_ACT) || (r_y < LP_V_ACT);
  assign w_req       = (r_x > LP_H_ACT) && (r_y > LP_V_ACT);

  logic [COORD_W-1:0] r_col, r_row;
  logic               r_req, r_ls, r_fs, r_hs0, r_vs0, r_blank0;

  // Stage 0 samples the pre-edge counter, so a resync edge still records the old position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col    <= '0;
      r_row    <= '0;
      r_req    <= 1'b0;
      r_ls     <= 1'b0;
      r_fs     <= 1'b0;
      r_hs0    <= 1'b0;
      r_vs0    <= 1'b0;
      r_blank0 <= 1'b1;
    end else if (en_i) begin
      r_col    <= r_x - LP_COL_SUB;
      r_row    <= r_y - LP_ROW_SUB;
      r_req    <= w_req;
      r_ls     <= (r_x == '0);
      r_fs     <= (r_x == '0) && (r_y == '0);
      r_hs0    <= w_hs_act;
      r_vs0    <= w_vs_act;
      r_blank0 <= w_blank_act;
    end
  end

  logic [2:0] w_dly_out;  // {hs_act, vs_act, blank_act}

  generate
    if (PIPE_DELAY == 0) begin : g_no_dly
      assign w_dly_out = {r_hs0, r_vs0, r_blank0};
    end else begin : g_dly
      logic [2:0] r_dly [PIPE_DELAY];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < PIPE_DELAY; i++) r_dly[i] <= 3'b001;
        end else if (en_i) begin
          r_dly[0] <= {r_hs0, r_vs0, r_blank0};
          for (int i = 1; i < PIPE_DELAY; i++) r_dly[i] <= r_dly[i-1];
        end
      end
      assign w_dly_out = r_dly[PIPE_DELAY-1];
    end
  endgenerate

  assign x_count       = r_x;
  assign y_count       = r_y;
  assign col           = r_col;
  assign row           = r_row;
  assign req_o         = r_req;
  assign line_start_o  = r_ls;
  assign frame_start_o = r_fs;
  assign hs_o          = w_dly_out[2] ^ LP_HS_INV;
  assign vs_o          = w_dly_out[1] ^ LP_VS_INV;
  assign blank_no      = ~w_dly_out[0];

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: a default instance and a small, delayed, active-high-sync instance
// share inputs and are compared each cycle against a position-history reference model.
module tb_vid_timing_gen;

  logic clk = 1'b0, rst = 1'b1, en_i = 1'b0, resync_i = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] xa, ya, cola, rowa, xb, yb, colb, rowb;
  logic reqa, lsa, fsa, hsa, vsa, bna, reqb, lsb, fsb, hsb, vsb, bnb;

  vid_timing_gen u_a (
    .clk(clk), .rst(rst), .en_i(en_i), .resync_i(resync_i),
    .x_count(xa), .y_count(ya), .col(cola), .row(rowa), .req_o(reqa),
    .line_start_o(lsa), .frame_start_o(fsa), .hs_o(hsa), .vs_o(vsa), .blank_no(bna));

  vid_timing_gen #(
    .H_TOTAL(40), .H_ACT_START(12), .H_SYNC_START(2), .H_SYNC_END(7),
    .V_TOTAL(20), .V_ACT_START(6), .V_SYNC_START(2), .V_SYNC_END(3),
    .COL_OFS(4), .ROW_OFS(2), .PIPE_DELAY(3), .HS_POL(1), .VS_POL(1)
  ) u_b (
    .clk(clk), .rst(rst), .en_i(en_i), .resync_i(resync_i),
    .x_count(xb), .y_count(yb), .col(colb), .row(rowb), .req_o(reqb),
    .line_start_o(lsb), .frame_start_o(fsb), .hs_o(hsb), .vs_o(vsb), .blank_no(bnb));

  int checks = 0, errors = 0;

  // Reference: current position plus the positions present at each enabled edge.
  int ax, ay, bx, by;
  int qax[$], qay[$], qbx[$], qby[$];
  bit phase1 = 0, stat_on = 0;
  int fs_b_cnt = 0, ls_b_cnt = 0, ls_a_cnt = 0;
  int hs_low_cnt = 0, req_cnt = 0, bn_cnt = 0;

  function automatic logic [57:0] expect_vec(input int x, input int y, input int qx[$], input int qy[$],
      input int has, input int hss, input int hse, input int vas, input int vss, input int vse,
      input int cofs, input int rofs, input int dly, input int hpol, input int vpol);
    logic [12:0] c, r;
    logic rq, ls, fs, hs, vs, bn;
    int n, px, py;
    n  = qx.size();
    c  = '0; r = '0; rq = 0; ls = 0; fs = 0;
    hs = (hpol == 0); vs = (vpol == 0); bn = 0;
    if (n > 0) begin
      px = qx[n-1]; py = qy[n-1];
      c  = 13'(px - has - cofs);
      r  = 13'(py - vas - rofs);
      rq = (px > has) && (py > vas);
      ls = (px == 0);
      fs = (px == 0) && (py == 0);
    end
    if (n > dly) begin
      px = qx[n-1-dly]; py = qy[n-1-dly];
      hs = ((px >= hss) && (px <= hse)) ^ (hpol == 0);
      vs = ((py >= vss) && (py <= vse)) ^ (vpol == 0);
      bn = !((px < has) || (py < vas));
    end
    return {13'(x), 13'(y), c, r, rq, ls, fs, hs, vs, bn};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ax = 0; ay = 0; bx = 0; by = 0;
    qax.delete(); qay.delete(); qbx.delete(); qby.delete();
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else begin
      if (en_i) begin
        qax.push_back(ax); qay.push_back(ay); qbx.push_back(bx); qby.push_back(by);
        if (qax.size() > 16) begin
          void'(qax.pop_front()); void'(qay.pop_front());
          void'(qbx.pop_front()); void'(qby.pop_front());
        end
      end
      if (resync_i) begin
        ax = 0; ay = 0; bx = 0; by = 0;
      end else if (en_i) begin
        ax++; if (ax == 800) begin ax = 0; ay++; if (ay == 525) ay = 0; end
        bx++; if (bx == 40)  begin bx = 0; by++; if (by == 20)  by = 0; end
      end
    end
  endtask

  task automatic check_all(input string tag);
    int px, py;
    chk({tag, "_a"}, 64'({xa, ya, cola, rowa, reqa, lsa, fsa, hsa, vsa, bna}),
        64'(expect_vec(ax, ay, qax, qay, 160, 2, 97, 45, 13, 14, 4, 2, 0, 0, 0)));
    chk({tag, "_b"}, 64'({xb, yb, colb, rowb, reqb, lsb, fsb, hsb, vsb, bnb}),
        64'(expect_vec(bx, by, qbx, qby, 12, 2, 7, 6, 2, 3, 4, 2, 3, 1, 1)));
    if (phase1) begin
      fs_b_cnt += int'(fsb); ls_b_cnt += int'(lsb); ls_a_cnt += int'(lsa);
    end
    if (stat_on && qax.size() > 0) begin
      px = qax[qax.size()-1]; py = qay[qay.size()-1];
      if (py == 46) hs_low_cnt += int'(!hsa);
      if (py == 47) begin req_cnt += int'(reqa); bn_cnt += int'(bna); end
      if (px == 164 && py == 47) chk("col_zero_at_x164", 64'(cola), 64'(0));
      if (px == 0 && py == 47)   chk("row_zero_at_y47", 64'(rowa), 64'(0));
      if (px == 1 && py == 46)   chk("hs_high_before_x2", 64'(hsa), 64'(1));
      if (px == 2 && py == 46)   chk("hs_low_at_x2", 64'(hsa), 64'(0));
    end
  endtask

  task automatic cycle(input logic e, input logic r, input string tag);
    en_i = e; resync_i = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    int lim;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // Continuous run: line/frame strobe cadence.
    phase1 = 1;
    for (int i = 0; i < 1200; i++) cycle(1'b1, 1'b0, "run");
    phase1 = 0;
    chk("frame_start_b_count", 64'(fs_b_cnt), 64'(2));
    chk("line_start_b_count", 64'(ls_b_cnt), 64'(30));
    chk("line_start_a_count", 64'(ls_a_cnt), 64'(2));

    // Random enable and occasional resync.
    for (int i = 0; i < 3000; i++)
      cycle(1'(($urandom % 8) != 0), 1'(($urandom % 200) == 0), "rand");

    // Long enabled run into the active region of the default instance.
    stat_on = 1;
    lim = 0;
    while (!(ay == 49 && ax == 0) && lim < 45000) begin
      cycle(1'b1, 1'b0, "long");
      lim++;
    end
    stat_on = 0;
    chk("reach_line49_timeout", 64'(lim < 45000), 64'(1));
    chk("hs_low_cycles_line46", 64'(hs_low_cnt), 64'(96));
    chk("req_cycles_line47", 64'(req_cnt), 64'(639));
    chk("blank_no_cycles_line47", 64'(bn_cnt), 64'(640));

    // Freeze for 10 cycles at x=300.
    lim = 0;
    while (ax != 300 && lim < 900) begin cycle(1'b1, 1'b0, "seek"); lim++; end
    chk("seek_x300_timeout", 64'(lim < 900), 64'(1));
    chk("x_at_freeze", 64'(xa), 64'(300));
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, "freeze");
    chk("x_after_freeze", 64'(xa), 64'(300));
    cycle(1'b1, 1'b0, "resume");
    chk("x_resumed", 64'(xa), 64'(301));

    // Resync with enable, then with enable low.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, "pre_resync");
    cycle(1'b1, 1'b1, "resync");
    chk("resync_x", 64'({xa, ya}), 64'(0));
    for (int i = 0; i < 20; i++) cycle(1'(($urandom % 4) != 0), 1'b0, "post_resync");
    cycle(1'b0, 1'b1, "resync_no_en");
    chk("resync_no_en_xy", 64'({xb, yb}), 64'(0));
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, "post_resync2");

    // Asynchronous reset away from any clock edge.
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_a", 64'({hsa, vsa, bna, reqa, xa}), 64'({1'b1, 1'b1, 1'b0, 1'b0, 13'd0}));
    chk("async_rst_b", 64'({hsb, vsb, bnb}), 64'({1'b0, 1'b0, 1'b0}));
    check_all("async_rst");
    @(posedge clk);
    model_step();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
